bus_tristate_driver: RTL and testbench

- Parameterised tri-state driver that connects one register's value onto the shared system bus of the 8-bit computer, e.g. the program counter's 4-bit output onto the address/data bus.
- The drive path is purely combinational, so there is zero latency from enable to bus.
- A small clocked monitor block samples the bus, reports drive status, and flags contention: bus value differing from the driven value while enabled.

---
 rtl/bus_pkg.sv | 8 +
 rtl/bus_monitor.sv | 72 +++++++
 rtl/bus_tristate_driver.sv | 37 +++
 tb/tb_bus_tristate_driver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the bus driver slice.
// Default bus width and enable settle window.
package bus_pkg;

    localparam int BUS_WIDTH  = 4;
    localparam int BUS_SETTLE = 1;

endpackage

// File: rtl/bus_monitor.sv
// Clocked monitor for one tri-state bus driver.
// Samples the bus, tracks drive status, flags contention.
module bus_monitor
    import bus_pkg::*;
#(
    parameter int WIDTH  = BUS_WIDTH,
    parameter int SETTLE = BUS_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             active_out,
    input  logic [WIDTH-1:0] bus,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bus_q,
    output logic             driving,
    output logic             contention
);

    localparam logic [1:0] SETTLE_LD = 2'(SETTLE);

    logic [WIDTH-1:0] resolved;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic             rise;
    logic             mismatch;

    // Floating or unknown bus bits read as 0.
    always_comb begin
        resolved = '0;
        for (int i = 0; i < WIDTH; i++) begin
            resolved[i] = (bus[i] === 1'b1);
        end
    end

    assign rise = active_out & ~driving;

    // Settle window: load on enable rise, count down, clear on release.
    always_comb begin
        cnt_nxt = cnt;
        if (!active_out) begin
            cnt_nxt = 2'd0;
        end else if (rise) begin
            cnt_nxt = SETTLE_LD;
        end else if (cnt != 2'd0) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    assign mismatch = active_out & (cnt == 2'd0) & ~rise
                    & (resolved != a);

    // Monitor registers; clear beats a new contention event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_q      <= '0;
            driving    <= 1'b0;
            cnt        <= 2'd0;
            contention <= 1'b0;
        end else begin
            bus_q   <= resolved;
            driving <= active_out;
            cnt     <= cnt_nxt;
            if (clr_err) begin
                contention <= 1'b0;
            end else if (mismatch) begin
                contention <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_tristate_driver.sv
// Tri-state driver placing a register value on the shared bus.
// Drive path is combinational; monitoring is clocked.
module bus_tristate_driver
    import bus_pkg::*;
#(
    parameter int WIDTH  = BUS_WIDTH,
    parameter int SETTLE = BUS_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             active_out,
    inout  wire  [WIDTH-1:0] out,
    output logic [WIDTH-1:0] bus_q,
    output logic             driving,
    output logic             contention,
    input  logic             clr_err
);

    assign out = active_out ? a : {WIDTH{1'bz}};

    bus_monitor #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) u_mon (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .active_out (active_out),
        .bus        (out),
        .clr_err    (clr_err),
        .bus_q      (bus_q),
        .driving    (driving),
        .contention (contention)
    );

endmodule

// File: tb/tb_bus_tristate_driver.sv
// Bench for bus_tristate_driver: directed plan plus random
// traffic against a cycle-age reference model.
module tb_bus_tristate_driver;

    localparam int W  = 4;
    localparam int ST = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic         active_out;
    logic         clr_err;
    logic         ext_en;
    logic [W-1:0] ext_val;
    wire  [W-1:0] bus;
    logic [W-1:0] bus_q;
    logic         driving;
    logic         contention;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign bus = ext_en ? ext_val : {W{1'bz}};

    bus_tristate_driver #(
        .WIDTH  (W),
        .SETTLE (ST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .active_out (active_out),
        .out        (bus),
        .bus_q      (bus_q),
        .driving    (driving),
        .contention (contention),
        .clr_err    (clr_err)
    );

    function automatic logic [W-1:0] res(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[i] = (v[i] === 1'b1);
        return r;
    endfunction

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: counts edges since the enable came up
    // and only trusts the bus once that age exceeds ST.
    logic [W-1:0] m_q;
    bit           m_drv;
    bit           m_cont;
    int           age;

    always @(posedge clk) begin
        logic [W-1:0] rb;
        bit           bad;
        rb  = res(bus);
        bad = 1'b0;
        if (!rst_n) begin
            m_q    = '0;
            m_drv  = 1'b0;
            m_cont = 1'b0;
            age    = 0;
        end else begin
            if (active_out) begin
                if (!m_drv) age = 0;
                else if (age < 1000) age = age + 1;
                bad = (age > ST) && (rb != a);
            end else begin
                age = 0;
            end
            if (clr_err) m_cont = 1'b0;
            else if (bad) m_cont = 1'b1;
            m_q   = rb;
            m_drv = active_out;
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check("bus_q", 16'(bus_q), 16'(m_q));
        check("driving", 16'(driving), 16'(m_drv));
        check("contention", 16'(contention), 16'(m_cont));
    endtask

    task automatic drive_chk();
        #1;
        if (!ext_en) begin
            if (active_out) check("drive", 16'(res(bus)), 16'(a));
            else check("release", 16'(res(bus)), 16'd0);
        end else if (!active_out) begin
            check("ext_bus", 16'(res(bus)), 16'(ext_val));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        a          = '0;
        active_out = 1'b0;
        clr_err    = 1'b0;
        ext_en     = 1'b0;
        ext_val    = '0;
        drive_chk();
        cycle();
        cycle();
        check("rst_q", 16'(bus_q), 16'd0);
        check("rst_cont", 16'(contention), 16'd0);

        rst_n      = 1'b1;
        a          = 4'b1010;
        active_out = 1'b1;
        drive_chk();
        cycle();
        check("drv_1", 16'(driving), 16'd1);
        cycle();
        check("q_1010", 16'(bus_q), 16'hA);

        active_out = 1'b0;
        ext_en     = 1'b1;
        ext_val    = 4'b0110;
        drive_chk();
        cycle();
        check("q_0110", 16'(bus_q), 16'h6);
        check("rel_cont", 16'(contention), 16'd0);
        ext_en = 1'b0;
        cycle();

        a          = 4'b0011;
        active_out = 1'b1;
        drive_chk();
        cycle();
        cycle();
        ext_en  = 1'b1;
        ext_val = 4'b0100;
        cycle();
        check("cont_set", 16'(contention), 16'd1);
        ext_en = 1'b0;
        cycle();
        check("cont_hold", 16'(contention), 16'd1);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        check("cont_clr", 16'(contention), 16'd0);

        active_out = 1'b0;
        cycle();
        active_out = 1'b1;
        ext_en     = 1'b1;
        cycle();
        cycle();
        ext_en = 1'b0;
        cycle();
        check("settle_mask", 16'(contention), 16'd0);

        ext_en = 1'b1;
        cycle();
        ext_en = 1'b0;
        a      = 4'b1111;
        cycle();
        check("pre_rst", 16'(contention), 16'd1);
        rst_n = 1'b0;
        drive_chk();
        cycle();
        check("rst_drive", 16'(res(bus)), 16'hF);
        check("rst_cont2", 16'(contention), 16'd0);
        check("rst_q2", 16'(bus_q), 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) active_out = ~active_out;
            a       = W'($urandom);
            ext_en  = ($urandom_range(5) == 0);
            ext_val = W'($urandom);
            clr_err = ($urandom_range(9) == 0);
            rst_n   = ($urandom_range(39) != 0);
            drive_chk();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
